// File: rtl/serial_flash_writer.sv
`default_nettype none
// ============================================================================
// serial_flash_writer -- byte-framed W/E/R command decoder driving a flash controller
// Option: SERIAL_FLASH_WRITER_VERIFY_EN adds read-back verify after each write
// Revision: 1.0
// ============================================================================
module serial_flash_writer #(
   parameter int MAIN_CLK   = 27_000_000,
   parameter int TIMEOUT_MS = 100,
   parameter int BITS       = 8,
   parameter int ADDR_WORDS = 3
) (
   input  logic                       clk27,
   input  logic                       rst,
   input  logic [BITS-1:0]            rx_data,
   input  logic                       rx_valid,
   output logic [BITS-1:0]            tx_data,
   output logic                       tx_enable,
   input  logic                       tx_word_finished,
   output logic                       flash_enable,
   output logic                       flash_write,
   output logic                       flash_erase,
   output logic [BITS*ADDR_WORDS-1:0] flash_addr,
   output logic [BITS-1:0]            flash_wdata,
   input  logic [BITS-1:0]            flash_rdata,
   input  logic                       flash_word_finished,
   input  logic                       flash_next_word,
   input  logic                       flash_ready,
   output logic                       busy
);

   localparam int ADDR_W      = BITS * ADDR_WORDS;
   localparam int CNT_W       = $clog2(ADDR_WORDS) + 1;
   localparam int TIMEOUT_CYC = MAIN_CLK / 1000 * TIMEOUT_MS;
   localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);

   localparam logic [BITS-1:0] CH_W     = BITS'(8'h57);
   localparam logic [BITS-1:0] CH_E     = BITS'(8'h45);
   localparam logic [BITS-1:0] CH_R     = BITS'(8'h52);
   localparam logic [BITS-1:0] CH_OK    = BITS'(8'h4B);
   localparam logic [BITS-1:0] CH_BAD   = BITS'(8'h58);
   localparam logic [BITS-1:0] CH_UNKWN = BITS'(8'h3F);

   typedef enum logic [3:0] {
      S_IDLE, S_RECV_ADDR, S_RECV_DATA, S_ERASE, S_WAIT_ERASE,
      S_WRITE, S_WAIT_WRITE, S_READ, S_REPLY
`ifdef SERIAL_FLASH_WRITER_VERIFY_EN
      , S_VERIFY
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [BITS-1:0]   cmd_q, cmd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BITS-1:0]   wdata_q, wdata_d;
   logic [BITS-1:0]   tx_data_q, tx_data_d;
   logic [TO_W-1:0]   timeout_q, timeout_d;
   logic              next_word_q, word_fin_q, tx_fin_q;

   logic nw_rise, wf_fall, txf_rise;
   assign nw_rise  = flash_next_word & ~next_word_q;
   assign wf_fall  = ~flash_word_finished & word_fin_q;
   assign txf_rise = tx_word_finished & ~tx_fin_q;

   always_ff @(posedge clk27 or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cmd_q       <= '0;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         tx_data_q   <= '0;
         timeout_q   <= '0;
         next_word_q <= 1'b0;
         word_fin_q  <= 1'b0;
         tx_fin_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         tx_data_q   <= tx_data_d;
         timeout_q   <= timeout_d;
         next_word_q <= flash_next_word;
         word_fin_q  <= flash_word_finished;
         tx_fin_q    <= tx_word_finished;
      end
   end

   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      tx_data_d    = tx_data_q;
      timeout_d    = timeout_q;
      flash_enable = 1'b0;
      flash_write  = 1'b0;
      flash_erase  = 1'b0;
      tx_enable    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rx_valid) begin
               if (rx_data == CH_W || rx_data == CH_E || rx_data == CH_R) begin
                  cmd_d     = rx_data;
                  cnt_d     = '0;
                  timeout_d = '0;
                  state_d   = S_RECV_ADDR;
               end else begin
                  tx_data_d = CH_UNKWN;
                  state_d   = S_REPLY;
               end
            end
         end
         S_RECV_ADDR: begin
            if (rx_valid) begin
               // Left shift: the first address byte on the wire ends up as the MSB.
               addr_d    = ADDR_W'({addr_q, rx_data});
               cnt_d     = cnt_q + 1'b1;
               timeout_d = '0;
               if (cnt_q == CNT_W'(ADDR_WORDS - 1)) begin
                  if (cmd_q == CH_W)      state_d = S_RECV_DATA;
                  else if (cmd_q == CH_E) state_d = S_ERASE;
                  else                    state_d = S_READ;
               end
            end else if (timeout_q == TO_W'(TIMEOUT_CYC)) begin
               timeout_d = '0;
               state_d   = S_IDLE;
            end else begin
               timeout_d = timeout_q + 1'b1;
            end
         end
         S_RECV_DATA: begin
            if (rx_valid) begin
               wdata_d   = rx_data;
               timeout_d = '0;
               state_d   = S_WRITE;
            end else if (timeout_q == TO_W'(TIMEOUT_CYC)) begin
               timeout_d = '0;
               state_d   = S_IDLE;
            end else begin
               timeout_d = timeout_q + 1'b1;
            end
         end
         S_ERASE: begin
            // Command lines drop in the same cycle the controller accepts the word.
            flash_enable = ~nw_rise;
            flash_write  = ~nw_rise;
            flash_erase  = ~nw_rise;
            if (nw_rise) state_d = S_WAIT_ERASE;
         end
         S_WRITE: begin
            flash_enable = ~nw_rise;
            flash_write  = ~nw_rise;
            if (nw_rise) state_d = S_WAIT_WRITE;
         end
         S_WAIT_ERASE: begin
            if (flash_ready) begin
               tx_data_d = CH_OK;
               state_d   = S_REPLY;
            end
         end
         S_WAIT_WRITE: begin
            if (flash_ready) begin
`ifdef SERIAL_FLASH_WRITER_VERIFY_EN
               state_d   = S_VERIFY;
`else
               tx_data_d = CH_OK;
               state_d   = S_REPLY;
`endif
            end
         end
         S_READ: begin
            flash_enable = 1'b1;
            if (wf_fall) begin
               tx_data_d = flash_rdata;
               state_d   = S_REPLY;
            end
         end
`ifdef SERIAL_FLASH_WRITER_VERIFY_EN
         S_VERIFY: begin
            flash_enable = 1'b1;
            if (wf_fall) begin
               tx_data_d = (flash_rdata == wdata_q) ? CH_OK : CH_BAD;
               state_d   = S_REPLY;
            end
         end
`endif
         S_REPLY: begin
            tx_enable = ~txf_rise;
            if (txf_rise) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy        = (state_q != S_IDLE);
   assign tx_data     = tx_data_q;
   assign flash_addr  = addr_q;
   assign flash_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_flash_writer.sv
`default_nettype none
// ============================================================================
// tb_serial_flash_writer -- directed self-checking bench for serial_flash_writer
// Revision: 1.0
// ============================================================================
module tb_serial_flash_writer;

   logic        clk27 = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_enable;
   logic        tx_word_finished = 1'b0;
   logic        flash_enable, flash_write, flash_erase;
   logic [23:0] flash_addr;
   logic [7:0]  flash_wdata;
   logic [7:0]  flash_rdata = '0;
   logic        flash_word_finished = 1'b0;
   logic        flash_next_word = 1'b0;
   logic        flash_ready = 1'b0;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // 10 kHz nominal clock with 100 ms timeout gives a 1000-cycle limit.
   serial_flash_writer #(
      .MAIN_CLK(10_000), .TIMEOUT_MS(100), .BITS(8), .ADDR_WORDS(3)
   ) dut (
      .clk27(clk27), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_enable(tx_enable), .tx_word_finished(tx_word_finished),
      .flash_enable(flash_enable), .flash_write(flash_write), .flash_erase(flash_erase),
      .flash_addr(flash_addr), .flash_wdata(flash_wdata), .flash_rdata(flash_rdata),
      .flash_word_finished(flash_word_finished), .flash_next_word(flash_next_word),
      .flash_ready(flash_ready), .busy(busy)
   );

   always #5 clk27 = ~clk27;

   task automatic tick();
      @(posedge clk27);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic finish_reply(input string tag);
      tx_word_finished = 1'b1;
      #1;
      chk({tag, "_txen_drop"}, tx_enable, 1'b0);
      tick();
      tx_word_finished = 1'b0;
      chk({tag, "_idle"}, busy, 1'b0);
      tick();
   endtask

   // Write frame through to the reply; vrd is the read-back data for verify builds.
   task automatic write_frame(input logic [7:0] a2, a1, a0, d, vrd, exp_reply);
      send_byte(8'h57);
      chk("wr_busy", busy, 1'b1);
      send_byte(a2); send_byte(a1); send_byte(a0); send_byte(d);
      chk("wr_en",    flash_enable, 1'b1);
      chk("wr_write", flash_write, 1'b1);
      chk("wr_erase", flash_erase, 1'b0);
      chk("wr_addr",  flash_addr, {a2, a1, a0});
      chk("wr_wdata", flash_wdata, d);
      flash_next_word = 1'b1;
      #1;
      chk("wr_en_drop", flash_enable, 1'b0);
      tick();
      flash_next_word = 1'b0;
      chk("wr_wait_en", flash_enable, 1'b0);
      flash_ready = 1'b1;
      tick();
      flash_ready = 1'b0;
`ifdef SERIAL_FLASH_WRITER_VERIFY_EN
      chk("vf_en", flash_enable, 1'b1);
      flash_rdata = vrd;
      flash_word_finished = 1'b1;
      tick();
      flash_word_finished = 1'b0;
      tick();
`endif
      chk("wr_txen", tx_enable, 1'b1);
      chk("wr_reply", tx_data, exp_reply);
      finish_reply("wr");
   endtask

   initial begin
      int n;
      logic seen;

      tick(); tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_txen", tx_enable, 1'b0);
      chk("rst_txdata", tx_data, 8'h00);
      chk("rst_fen", flash_enable, 1'b0);
      chk("rst_addr", flash_addr, 24'h0);
      chk("rst_wdata", flash_wdata, 8'h00);
      rst = 1'b0;
      tick();

      write_frame(8'h00, 8'h01, 8'h02, 8'h23, 8'h23, 8'h4B);

      // Read: enable held until the falling edge of word_finished.
      flash_rdata = 8'h5A;
      send_byte(8'h52);
      send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h00);
      chk("rd_en", flash_enable, 1'b1);
      chk("rd_write", flash_write, 1'b0);
      chk("rd_addr", flash_addr, 24'hABCD00);
      tick(); tick();
      chk("rd_hold", flash_enable, 1'b1);
      flash_word_finished = 1'b1;
      tick();
      chk("rd_hold_rise", flash_enable, 1'b1);
      flash_word_finished = 1'b0;
      tick();
      chk("rd_txen", tx_enable, 1'b1);
      chk("rd_reply", tx_data, 8'h5A);
      chk("rd_en_off", flash_enable, 1'b0);
      finish_reply("rd");

      // Unknown command, plus a byte dropped while replying.
      send_byte(8'h51);
      chk("q_txen", tx_enable, 1'b1);
      chk("q_reply", tx_data, 8'h3F);
      chk("q_fen", flash_enable, 1'b0);
      send_byte(8'h57);
      chk("q_drop_reply", tx_data, 8'h3F);
      finish_reply("q");

      // Timeout mid-address.
      send_byte(8'h45);
      send_byte(8'h12);
      seen = 1'b0;
      for (int i = 0; i < 990; i++) begin
         if (flash_enable || tx_enable) seen = 1'b1;
         tick();
      end
      chk("to_busy_early", busy, 1'b1);
      n = 0;
      while (busy && n < 100) begin
         if (flash_enable || tx_enable) seen = 1'b1;
         tick();
         n++;
      end
      chk("to_idle", busy, 1'b0);
      chk("to_silent", seen, 1'b0);

      // Erase.
      send_byte(8'h45);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
      chk("er_en", flash_enable, 1'b1);
      chk("er_write", flash_write, 1'b1);
      chk("er_erase", flash_erase, 1'b1);
      chk("er_addr", flash_addr, 24'h123456);
      flash_next_word = 1'b1;
      #1;
      chk("er_erase_drop", flash_erase, 1'b0);
      tick();
      flash_next_word = 1'b0;
      flash_ready = 1'b1;
      tick();
      flash_ready = 1'b0;
      chk("er_reply", tx_data, 8'h4B);
      finish_reply("er");

`ifdef SERIAL_FLASH_WRITER_VERIFY_EN
      write_frame(8'h00, 8'h01, 8'h02, 8'h23, 8'h22, 8'h58);
`endif

      // Asynchronous reset while a write is pending.
      send_byte(8'h57);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      chk("rw_en", flash_enable, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("rw_fen", flash_enable, 1'b0);
      chk("rw_busy", busy, 1'b0);
      chk("rw_wdata", flash_wdata, 8'h00);
      tick();
      rst = 1'b0;
      send_byte(8'h51);
      chk("rw_first_byte", tx_enable, 1'b1);
      finish_reply("rw");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_flash_writer.md
SERIAL_FLASH_WRITER -- requirements
Module: serial_flash_writer

Interface
REQ-001 Parameter MAIN_CLK, default 27_000_000, main clock frequency in Hz.
REQ-002 Parameter TIMEOUT_MS, default 100, maximum gap between bytes of one command frame.
REQ-003 Parameter BITS, default 8, width of a data word.
REQ-004 Parameter ADDR_WORDS, default 3, number of address bytes per frame.
REQ-005 clk27  in  1  main clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 rx_data  in  BITS  received byte from the serial receiver.
REQ-008 rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-009 tx_data  out  BITS  reply byte to the serial transmitter.
REQ-010 tx_enable  out  1  transmitter enable.
REQ-011 tx_word_finished  in  1  transmitter word done; the rising edge ends a byte.
REQ-012 flash_enable, flash_write, flash_erase  out  1 each  flash controller command lines.
REQ-013 flash_addr  out  BITS*ADDR_WORDS  flash address, MSB byte first on the wire.
REQ-014 flash_wdata  out  BITS  write data.
REQ-015 flash_rdata  in  BITS  read data.
REQ-016 flash_word_finished, flash_next_word, flash_ready  in  1 each  controller status.
REQ-017 busy  out  1  high in every state except Idle.

Function
REQ-018 Frames: 'W' a2 a1 a0 d (write); 'E' a2 a1 a0 (erase the sector containing the address); 'R' a2 a1 a0 (read).
REQ-019 States: Idle, RecvAddr, RecvData, Erase, WaitErase, Write, WaitWrite, Read, Reply.
REQ-020 Idle, rx_valid with 'W', 'E' or 'R': latch the command, clear the byte counter, go to RecvAddr.
REQ-021 Idle, rx_valid with any other byte: go to Reply with tx_data = '?'.
REQ-022 RecvAddr: each rx_valid shifts rx_data into flash_addr from the MSB side.
REQ-023 RecvAddr exit after ADDR_WORDS bytes: W goes to RecvData, E goes to Erase, R goes to Read.
REQ-024 RecvData: rx_valid latches flash_wdata, then go to Write.
REQ-025 Timeout counter clears on every accepted byte and counts only in RecvAddr and RecvData.
REQ-026 Timeout reaching MAIN_CLK/1000*TIMEOUT_MS: discard the frame and return to Idle with no reply.
REQ-027 Erase: hold flash_enable=flash_write=flash_erase=1.
REQ-028 Erase, on the rising edge of flash_next_word: deassert all three combinationally in the same cycle, go to WaitErase.
REQ-029 Write: identical to Erase but with flash_erase=0, driving flash_wdata; exit goes to WaitWrite.
REQ-030 WaitErase or WaitWrite: with flash_ready=1, go to Reply with 'K' (see REQ-044).
REQ-031 Read: hold flash_enable=1.
REQ-032 Read, on the falling edge of flash_word_finished: capture flash_rdata into tx_data, go to Reply.
REQ-033 Reply: hold tx_enable=1.
REQ-034 Reply, on the rising edge of tx_word_finished: deassert tx_enable in the same cycle, go to Idle.
REQ-035 Edge detection uses one registered copy per status input; the edge is qualified in the same cycle.
REQ-036 rx_valid arriving in Erase, WaitErase, Write, WaitWrite, Read or Reply is dropped; it is not queued.
REQ-037 The byte counter is $clog2(ADDR_WORDS)+1 bits wide; no wrap within a frame.
REQ-038 All flash command outputs are 0 outside the Erase, Write and Read states.

Reset
REQ-039 rst forces the state to Idle at any time, including mid-flash-operation; flash_enable drops at once.
REQ-040 Reset values: tx_enable=0, tx_data=0, flash_*=0, flash_addr=0, flash_wdata=0, busy=0, timeout=0, edge registers=0.
REQ-041 After release, the first rx_valid in Idle is accepted in the next cycle.

Configuration
REQ-042 The macro SERIAL_FLASH_WRITER_VERIFY_EN selects the write-reply behaviour.
REQ-043 Without SERIAL_FLASH_WRITER_VERIFY_EN: WaitWrite goes straight to Reply 'K'.
REQ-044 With the macro defined: WaitWrite goes to a Verify state that performs a read as in REQ-031 and REQ-032.
REQ-045 In Verify, if flash_rdata equals flash_wdata reply 'K', else reply 'X'; erase replies are unaffected.

Verification
REQ-046 Bytes 'W',0x00,0x01,0x02,0x23, then flash_next_word pulse and flash_ready=1 -> one write with addr=0x000102 and wdata=0x23, followed by reply 'K'.
REQ-047 Bytes 'R',0xAB,0xCD,0x00 with flash_rdata=0x5A -> flash_enable held until the falling edge of flash_word_finished, then reply 0x5A.
REQ-048 Byte 'Q' -> reply '?' and no flash_enable pulse.
REQ-049 'E',0x12 followed by 100 ms of silence -> return to Idle, no flash command, no reply.
REQ-050 rst asserted during the Write state -> flash_enable=0 asynchronously and busy=0.
REQ-051 With VERIFY_EN, write 0x23 and read back 0x22 -> reply 'X'.
